// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate in front of a word-organised SRAM: byte/half/word access, two-cycle ERROR.
// Define AHB_SRAM_WAITSTATE_EN to insert WAIT_STATES stall cycles into every legal transfer.
module ahb_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_BYTES   = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
`ifdef AHB_SRAM_WAITSTATE_EN
        S_WAIT = 2'd3,
`endif
        S_ERR2 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             hready_q, hready_d;
    logic             resp_q, resp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             pend_wr_q, pend_wr_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [3:0]       wr_strb_q, wr_strb_d;
`ifdef AHB_SRAM_WAITSTATE_EN
    logic [3:0]       cnt_q, cnt_d;
`endif

    logic [31:0]           mem [WORDS];
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      acc_idx;
    logic [3:0]            acc_strb;
    logic                  legal;
    logic                  accept;
    logic                  commit;
    logic [31:0]           fwd_word;
    logic                  unused_inputs;

    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT};

    assign accept = HSEL & HREADY & HTRANS[1];
    // A write commits on the edge that ends its data phase; reset on that edge discards it.
    assign commit = pend_wr_q & hready_q & ~reset;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        offset   = HADDR - BASE_ADDR;
        acc_idx  = offset[IDX_W+1:2];
        legal    = ({1'b0, offset} < MEM_LIMIT);
        acc_strb = 4'b0000;
        case (HSIZE)
            3'b000: acc_strb = 4'b0001 << offset[1:0];
            3'b001: begin
                acc_strb = offset[1] ? 4'b1100 : 4'b0011;
                if (offset[0]) legal = 1'b0;
            end
            3'b010: begin
                acc_strb = 4'b1111;
                if (offset[1:0] != 2'b00) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    // Read-after-write: lanes committed on this edge to the same word bypass the array.
    always_comb begin
        fwd_word = mem[acc_idx];
        for (int b = 0; b < 4; b++) begin
            if (commit && (wr_idx_q == acc_idx) && wr_strb_q[b]) begin
                fwd_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hready_d  = hready_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        pend_wr_d = pend_wr_q;
        wr_idx_d  = wr_idx_q;
        wr_strb_d = wr_strb_q;
`ifdef AHB_SRAM_WAITSTATE_EN
        cnt_d     = cnt_q;
`endif
        if (hready_q) pend_wr_d = 1'b0;

        case (state_q)
            S_ERR1: begin
                state_d  = S_ERR2;
                hready_d = 1'b1;
                resp_d   = 1'b1;
            end
`ifdef AHB_SRAM_WAITSTATE_EN
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d  = S_IDLE;
                    hready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            default: begin
                // IDLE and ERR2 both take a new address phase.
                state_d  = S_IDLE;
                hready_d = 1'b1;
                resp_d   = 1'b0;
                if (accept) begin
                    if (!legal) begin
                        state_d  = S_ERR1;
                        hready_d = 1'b0;
                        resp_d   = 1'b1;
                    end else begin
                        pend_wr_d = HWRITE;
                        wr_idx_d  = acc_idx;
                        wr_strb_d = acc_strb;
                        if (!HWRITE) rdata_d = fwd_word;
`ifdef AHB_SRAM_WAITSTATE_EN
                        if (WAIT_STATES > 0) begin
                            state_d  = S_WAIT;
                            hready_d = 1'b0;
                            cnt_d    = 4'(WAIT_STATES);
                        end
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hready_q  <= 1'b1;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
            pend_wr_q <= 1'b0;
            wr_idx_q  <= '0;
            wr_strb_q <= '0;
`ifdef AHB_SRAM_WAITSTATE_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hready_q  <= hready_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            pend_wr_q <= pend_wr_d;
            wr_idx_q  <= wr_idx_d;
            wr_strb_q <= wr_strb_d;
`ifdef AHB_SRAM_WAITSTATE_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // NOTE: the SRAM array has no reset; its contents survive reset and power up undefined.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_q[b]) mem[wr_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HREADYOUT = hready_q;
    assign HRESP     = resp_q;
    assign HRDATA    = rdata_q;

endmodule
